// File: rtl/suma_acum_if.sv
`default_nettype none
// ============================================================================
// Module   : suma_acum_if
// Brief    : Beat/result handshake bundle for the suma_acum adder-accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface suma_acum_if #(
    parameter int WIDTH = 32,
    parameter int TAPS  = 9
);
    localparam int c_cnt_w = $clog2(TAPS + 1);

    logic               clear;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   s;
    logic               ovf;
    logic [c_cnt_w-1:0] count;

    modport master (
        output clear, mode, in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, ovf, count
    );

    modport slave (
        input  clear, mode, in_valid, a, b, out_ready,
        output in_ready, out_valid, s, ovf, count
    );
endinterface
`default_nettype wire

// File: rtl/suma_acum.sv
`default_nettype none
// ============================================================================
// Module   : suma_acum
// Brief    : Signed pairwise adder / TAPS-beat accumulator with saturating or
//            wrapping output and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module suma_acum #(
    parameter int WIDTH = 32,
    parameter int TAPS  = 9,
    parameter int SAT   = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    suma_acum_if.slave  bus
);
    localparam int c_acc_w = WIDTH + 1 + $clog2(TAPS);
    localparam int c_cnt_w = $clog2(TAPS + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TAPS - 1);
    localparam logic [WIDTH-1:0]   c_s_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_s_min = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_acc_w-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_s;
    logic                 r_ovf;
    logic                 r_out_valid;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_consume;
    logic [c_acc_w-1:0]   w_pair;
    logic [c_acc_w-1:0]   w_acc_next;
    logic [c_acc_w-1:0]   w_conv_in;
    logic [c_acc_w-WIDTH:0] w_conv_hi;
    logic                 w_out_of_range;
    logic [WIDTH-1:0]     w_res;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = r_out_valid && bus.out_ready;

    assign w_pair = {{(c_acc_w-WIDTH){bus.a[WIDTH-1]}}, bus.a}
                  + {{(c_acc_w-WIDTH){bus.b[WIDTH-1]}}, bus.b};
    assign w_acc_next = r_acc + w_pair;

    // The final accumulate beat converts the running total; every other
    // producing beat is a first beat, where only the pair matters.
    assign w_conv_in      = (r_state == ST_ACCUM) ? w_acc_next : w_pair;
    assign w_conv_hi      = w_conv_in[c_acc_w-1:WIDTH-1];
    assign w_out_of_range = !((&w_conv_hi) || !(|w_conv_hi));

    generate
        if (SAT != 0) begin : g_sat
            assign w_res = !w_out_of_range     ? w_conv_in[WIDTH-1:0] :
                           w_conv_in[c_acc_w-1] ? c_s_min : c_s_max;
        end else begin : g_wrap
            assign w_res = w_conv_in[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_s         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.clear) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (r_count == c_last) begin
                            r_s         <= w_res;
                            r_ovf       <= w_out_of_range;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_count     <= '0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc   <= w_acc_next;
                            r_count <= r_count + c_cnt_w'(1);
                        end
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    if (w_consume) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                    // In HOLD a beat is only accepted alongside a consume, so
                    // it opens the next window exactly as it would from IDLE.
                    if (w_accept) begin
                        if (!bus.mode) begin
                            r_s         <= w_res;
                            r_ovf       <= w_out_of_range;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc   <= w_pair;
                            r_count <= c_cnt_w'(1);
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_s;
    assign bus.ovf       = r_ovf;
    assign bus.count     = r_count;
endmodule
`default_nettype wire

// File: doc/suma_acum.md
SUMA_ACUM -- requirements
Module: suma_acum

Interface
REQ-001 Parameter WIDTH, default 32: signed operand and result width in bits.
REQ-002 Parameter TAPS, default 9: number of accepted beats per accumulation window; legal range is 2..256.
REQ-003 Parameter SAT, default 1: 1 clamps results to the signed WIDTH range; 0 wraps modulo 2^WIDTH.
REQ-004 clk  in  1: single clock; all registers update on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 clear  in  1: synchronous abort of the current window and of any pending result.
REQ-007 mode  in  1: 0 = pairwise sum per beat; 1 = accumulate over TAPS beats.
REQ-008 in_valid  in  1: a, b and mode are presented.
REQ-009 in_ready  out  1: block can accept a beat this cycle.
REQ-010 a  in  WIDTH: signed two's-complement operand.
REQ-011 b  in  WIDTH: signed two's-complement operand.
REQ-012 out_valid  out  1: s and ovf hold a result.
REQ-013 out_ready  in  1: consumer accepts the result this cycle.
REQ-014 s  out  WIDTH: signed result.
REQ-015 ovf  out  1: 1 = the result was clamped (SAT=1) or wrapped (SAT=0).
REQ-016 count  out  clog2(TAPS+1): number of beats accepted in the current window.

Function
REQ-017 Beat accepted: in_valid && in_ready on a rising edge.
REQ-018 Result consumed: out_valid && out_ready on a rising edge.
REQ-019 in_ready SHALL equal !out_valid || out_ready (combinational). This allows a result to be consumed and a new beat accepted in the same cycle.
REQ-020 FSM states:
- IDLE: count=0, accumulator=0.
- ACCUM: window open, 1 <= count < TAPS.
- HOLD: out_valid=1.
REQ-021 Mode latch: mode is sampled only on the first beat of a window (from IDLE). mode changes during ACCUM are ignored.
REQ-022 Pairwise mode, IDLE to HOLD:
- s = result(a+b), registered.
- Latency: 1 cycle from the accepting edge to out_valid=1.
REQ-023 Accumulate mode, first beat: IDLE to ACCUM, acc = a+b, count=1.
REQ-024 Accumulate mode, each further beat: acc += a+b, count increments.
REQ-025 Accumulate mode, beat TAPS: the FSM goes to HOLD and s = result(acc final). out_valid rises 1 cycle after the TAPS-th accepting edge. count returns to 0 on entry to HOLD.
REQ-026 Accumulator width: WIDTH+1+clog2(TAPS) bits, signed. No internal overflow is possible. Saturation/wrap is applied once, at output.
REQ-027 result(x) with SAT=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; ovf=1 iff clamped.
REQ-028 result(x) with SAT=0: s = x[WIDTH-1:0]; ovf=1 iff x lies outside the signed range.
REQ-029 HOLD: s, ovf and out_valid SHALL remain stable until consumed.
REQ-030 Consume with no simultaneous beat: the FSM goes to IDLE.
REQ-031 Consume with a simultaneous beat: the beat is processed as a first beat (REQ-022/023). This gives back-to-back pairwise throughput of 1 result per cycle.
REQ-032 clear=1 has priority over all other inputs and never blocks the next cycle. It forces IDLE, acc=0, count=0, out_valid=0, ovf=0. Any beat presented in the same cycle is dropped. s keeps its last value.
REQ-033 Beats with in_valid=0 leave the state, acc and count unchanged. There is no timeout.

Reset
REQ-034 On rst_n=0, immediately and independent of clk, the block SHALL go to IDLE with:
- acc=0, count=0
- out_valid=0, s=0, ovf=0
REQ-035 Reset asserted mid-window or in HOLD discards all partial and pending results.
REQ-036 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-037 Pairwise: mode=0, a=1, b=-5, then a=515, b=-12 on consecutive cycles, out_ready=1. Required: s=-4 then s=503, 1 cycle latency each, ovf=0, one result per cycle.
REQ-038 Saturation: SAT=1, mode=0, a=0x7FFFFFFF, b=1, then a=0x80000000, b=-1. Required: s=0x7FFFFFFF with ovf=1, then s=0x80000000 with ovf=1. With SAT=0, the same stimulus gives s=0x80000000 then 0x7FFFFFFF, ovf=1 both.
REQ-039 Accumulate: mode=1, TAPS=9, nine beats a=214, b=10 with gaps of in_valid=0 inserted. Required: out_valid only after the 9th beat, s=2016, count steps 1..8 then 0.
REQ-040 Backpressure: result held with out_ready=0 for 5 cycles. Required: in_ready=0, s stable. Then out_ready=1 with a simultaneous beat a=3, b=13: the old result is consumed and s=16 appears the next cycle.
REQ-041 Abort: after 4 accumulate beats, assert clear for 1 cycle, then run a fresh 9-beat window a=-124, b=0. Required: s=-1116, ovf=0.
REQ-042 Reset: assert rst_n=0 asynchronously in HOLD between clock edges. Required: out_valid=0 and count=0 immediately.
